arf_serial_engine: RTL and testbench

//  Time-multiplexed executor for the 28-node ARF dataflow graph (16 mul, 12 add).
//  - Consumes an operand frame over a valid/ready stream.
//  - Evaluates all nodes in topological order using one shared multiplier and one shared adder.
//  - Returns the two filter outputs (nodes 27, 28) over a valid/ready stream.
//  - Serves as the sequential, resource-constrained counterpart to the fully parallel ARF netlist.

---
 rtl/arf_pkg.sv | 74 +++++++
 rtl/arf_alu.sv | 27 ++
 rtl/arf_serial_engine.sv | 131 +++++++++++++
 tb/tb_arf_serial_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arf_pkg.sv
// Shared types, sizes and the node schedule for the serial ARF engine.
// Source index map: operands 0..17, coefficients 18..25, node results 26..53.
package arf_pkg;

  typedef enum logic {OP_MUL, OP_ADD} op_e;

  typedef logic [1:0] state_e;
  localparam state_e ST_IDLE    = 2'd0;
  localparam state_e ST_LOAD    = 2'd1;
  localparam state_e ST_COMPUTE = 2'd2;
  localparam state_e ST_OUT     = 2'd3;

  localparam int unsigned NUM_NODES   = 28;
  localparam int unsigned FRAME_BEATS = 18;
  localparam int unsigned NUM_COEFS   = 8;
  localparam int unsigned COEF_BASE   = FRAME_BEATS;
  localparam int unsigned NODE_BASE   = COEF_BASE + NUM_COEFS;
  localparam int unsigned NUM_SRC     = NODE_BASE + NUM_NODES;

  typedef logic [5:0] src_idx_t;

  typedef struct packed {
    op_e      op;
    src_idx_t src_a;
    src_idx_t src_b;
  } sched_t;

  localparam src_idx_t X13_IDX = 6'd16;
  localparam src_idx_t X14_IDX = 6'd17;

  // n is the 1-based node number used in the graph description
  function automatic src_idx_t nd(input int unsigned n);
    return src_idx_t'(NODE_BASE + n - 1);
  endfunction

  // k = 0..7 maps to c15,c16,c17,c18,c21,c22,c23,c24
  function automatic src_idx_t cf(input int unsigned k);
    return src_idx_t'(COEF_BASE + k);
  endfunction

  function automatic sched_t sched_lookup(input logic [4:0] idx);
    sched_t s;
    s = '{op: OP_ADD, src_a: '0, src_b: '0};
    if (idx < 5'd8) begin
      s = '{op: OP_MUL, src_a: src_idx_t'({idx, 1'b0}), src_b: src_idx_t'({idx, 1'b1})};
    end else begin
      case (idx)
        5'd8:    s = '{op: OP_ADD, src_a: nd(1),  src_b: nd(2)};
        5'd9:    s = '{op: OP_ADD, src_a: nd(3),  src_b: nd(4)};
        5'd10:   s = '{op: OP_ADD, src_a: nd(5),  src_b: nd(6)};
        5'd11:   s = '{op: OP_ADD, src_a: nd(7),  src_b: nd(8)};
        5'd12:   s = '{op: OP_ADD, src_a: nd(10), src_b: X13_IDX};
        5'd13:   s = '{op: OP_ADD, src_a: nd(11), src_b: X14_IDX};
        5'd14:   s = '{op: OP_MUL, src_a: nd(13), src_b: cf(0)};
        5'd15:   s = '{op: OP_MUL, src_a: nd(14), src_b: cf(1)};
        5'd16:   s = '{op: OP_MUL, src_a: nd(13), src_b: cf(2)};
        5'd17:   s = '{op: OP_MUL, src_a: nd(14), src_b: cf(3)};
        5'd18:   s = '{op: OP_ADD, src_a: nd(15), src_b: nd(16)};
        5'd19:   s = '{op: OP_ADD, src_a: nd(17), src_b: nd(18)};
        5'd20:   s = '{op: OP_MUL, src_a: nd(19), src_b: cf(4)};
        5'd21:   s = '{op: OP_MUL, src_a: nd(20), src_b: cf(5)};
        5'd22:   s = '{op: OP_MUL, src_a: nd(19), src_b: cf(6)};
        5'd23:   s = '{op: OP_MUL, src_a: nd(20), src_b: cf(7)};
        5'd24:   s = '{op: OP_ADD, src_a: nd(21), src_b: nd(22)};
        5'd25:   s = '{op: OP_ADD, src_a: nd(23), src_b: nd(24)};
        5'd26:   s = '{op: OP_ADD, src_a: nd(9),  src_b: nd(25)};
        5'd27:   s = '{op: OP_ADD, src_a: nd(12), src_b: nd(26)};
        default: s = '{op: OP_ADD, src_a: '0, src_b: '0};
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/arf_alu.sv
// Shared datapath: one truncating fixed-point multiplier and one wrapping adder.
module arf_alu
  import arf_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 0
) (
  input  op_e                  op,
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  output logic signed [W-1:0]  y
);

  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   mul_y;
  logic signed [W-1:0]   add_y;

  assign prod  = a * b;
  assign mul_y = W'(prod >>> FRAC);
  assign add_y = a + b;

  always_comb begin
    y = add_y;
    if (op == OP_MUL) y = mul_y;
  end

endmodule

// File: rtl/arf_serial_engine.sv
// Time-multiplexed ARF executor: loads an 18-beat operand frame, evaluates the
// 28 graph nodes one per cycle on a shared ALU, then streams out n27 and n28.
module arf_serial_engine
  import arf_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [W-1:0]  cfg_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
  output logic          m_last,
  output logic          busy
);

  localparam src_idx_t N27_IDX = src_idx_t'(NODE_BASE + 26);
  localparam src_idx_t N28_IDX = src_idx_t'(NODE_BASE + 27);

  state_e     state_q, state_d;
  logic [4:0] beat_q, beat_d;
  logic [4:0] node_q, node_d;
  logic       out_beat_q, out_beat_d;

  // Operands, coefficients and node results share one indexable file
  logic signed [W-1:0] regs_q [NUM_SRC];

  sched_t              sched;
  logic signed [W-1:0] alu_a, alu_b, alu_y;
  src_idx_t            beat_idx, cfg_idx, node_idx;
  logic                s_fire, cfg_fire;

  assign sched    = sched_lookup(node_q);
  assign alu_a    = regs_q[sched.src_a];
  assign alu_b    = regs_q[sched.src_b];
  assign beat_idx = src_idx_t'(beat_q);
  assign cfg_idx  = src_idx_t'(COEF_BASE) + src_idx_t'(cfg_addr);
  assign node_idx = src_idx_t'(NODE_BASE) + src_idx_t'(node_q);

  assign s_ready  = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_COMPUTE) || (state_q == ST_OUT);
  assign m_valid  = (state_q == ST_OUT);
  assign m_last   = m_valid && out_beat_q;
  assign m_data   = m_valid ? (out_beat_q ? regs_q[N28_IDX] : regs_q[N27_IDX]) : '0;
  assign s_fire   = s_valid && s_ready;
  // Coefficients are frozen while a frame is in flight
  assign cfg_fire = cfg_we && !busy;

  arf_alu #(
    .W    (W),
    .FRAC (FRAC)
  ) u_alu (
    .op (sched.op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    node_d     = node_q;
    out_beat_d = out_beat_q;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        if (s_fire) begin
          if (beat_q == 5'(FRAME_BEATS - 1)) begin
            beat_d  = '0;
            node_d  = '0;
            state_d = ST_COMPUTE;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      ST_COMPUTE: begin
        if (node_q == 5'(NUM_NODES - 1)) begin
          node_d     = '0;
          out_beat_d = 1'b0;
          state_d    = ST_OUT;
        end else begin
          node_d = node_q + 5'd1;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          if (out_beat_q) begin
            out_beat_d = 1'b0;
            state_d    = ST_LOAD;
          end else begin
            out_beat_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      node_q     <= '0;
      out_beat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      node_q     <= node_d;
      out_beat_q <= out_beat_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) regs_q[i] <= '0;
    end else begin
      if (s_fire)                   regs_q[beat_idx] <= s_data;
      if (cfg_fire)                 regs_q[cfg_idx]  <= cfg_data;
      if (state_q == ST_COMPUTE)    regs_q[node_idx] <= alu_y;
    end
  end

endmodule

// File: tb/tb_arf_serial_engine.sv
// Directed bench for arf_serial_engine; a FRAC=0 and a FRAC=8 instance run in lockstep.
module tb_arf_serial_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        s_valid;
  logic [15:0] s_data;
  logic        m_ready;
  logic        s_ready, m_valid, m_last, busy;
  logic [15:0] m_data;
  logic        s_ready8, m_valid8, m_last8, busy8;
  logic [15:0] m_data8;

  int checks = 0;
  int errors = 0;
  logic [15:0] frame [18];

  always #5 clk = ~clk;

  arf_serial_engine #(.W(16), .FRAC(0)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  arf_serial_engine #(.W(16), .FRAC(8)) dut8 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
    .m_valid(m_valid8), .m_ready(m_ready), .m_data(m_data8), .m_last(m_last8), .busy(busy8)
  );

  task automatic set_coefs(input logic [15:0] v);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = v;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic fill(input logic [15:0] a_v, input logic [15:0] b_v, input logic [15:0] x_v);
    for (int k = 0; k < 8; k++) begin
      frame[2*k]   = a_v;
      frame[2*k+1] = b_v;
    end
    frame[16] = x_v;
    frame[17] = x_v;
  endtask

  // Returns at the negedge following the last accepted beat
  task automatic send_frame(input int gap_at, output int waits);
    waits = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == gap_at) begin
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
      s_data = frame[i]; s_valid = 1'b1;
      while (!s_ready && waits < 100) begin
        @(negedge clk);
        waits++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Must be entered at a negedge; waits (bounded) for m_valid, then takes both beats
  task automatic collect(output logic [15:0] d0, output logic [15:0] d1,
                         output logic [15:0] e0, output logic [15:0] e1,
                         output logic v0, output logic l0, output logic l1, output int lat);
    lat = 0;
    while (!m_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    v0 = m_valid; d0 = m_data; e0 = m_data8; l0 = m_last;
    m_ready = 1'b1;
    @(negedge clk);
    d1 = m_data; e1 = m_data8; l1 = m_last;
    @(posedge clk);
    #1 m_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
    checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL reset_m_data got %h want 0000", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL idle_to_load got %b want 1", s_ready); end
  endtask

  task automatic test_basic;
    logic [15:0] d0, d1, e0, e1; logic v0, l0, l1; int lat, w;
    set_coefs(16'd1);
    fill(16'd1, 16'd1, 16'd0);
    send_frame(-1, w);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (lat !== 28) begin errors++; $display("FAIL basic_latency got %0d want 28", lat); end
    checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", v0); end
    checks++; if (d0 !== 16'd10) begin errors++; $display("FAIL basic_n27 got %0d want 10", d0); end
    checks++; if (d1 !== 16'd10) begin errors++; $display("FAIL basic_n28 got %0d want 10", d1); end
    checks++; if (l0 !== 1'b0) begin errors++; $display("FAIL basic_last0 got %b want 0", l0); end
    checks++; if (l1 !== 1'b1) begin errors++; $display("FAIL basic_last1 got %b want 1", l1); end
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL basic_after_out got v=%b l=%b r=%b want 0 0 1", m_valid, m_last, s_ready);
    end
  endtask

  task automatic test_vectors;
    logic [15:0] d0, d1, e0, e1; logic v0, l0, l1; int lat, w;
    set_coefs(16'd2);
    fill(16'd0, 16'd1, 16'd1);
    for (int k = 0; k < 8; k++) frame[2*k] = 16'(k + 1);
    send_frame(5, w);  // stall mid-frame
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (d0 !== 16'd163) begin errors++; $display("FAIL vec_n27 got %0d want 163", d0); end
    checks++; if (d1 !== 16'd175) begin errors++; $display("FAIL vec_n28 got %0d want 175", d1); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d0, d1, e0, e1; logic v0, l0, l1; int lat, w;
    send_frame(-1, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL b2b_load_wait got %0d want 0", w); end
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (d0 !== 16'd163) begin errors++; $display("FAIL b2b_n27 got %0d want 163", d0); end
    checks++; if (d1 !== 16'd175) begin errors++; $display("FAIL b2b_n28 got %0d want 175", d1); end
  endtask

  task automatic test_backpressure;
    logic [15:0] d0, d1, e0, e1; logic v0, l0, l1; int lat, w, n;
    set_coefs(16'd1);
    fill(16'd1, 16'd1, 16'd0);
    send_frame(-1, w);
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== 16'd10 || m_last !== 1'b0 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b d=%0d l=%b r=%b want 1 10 0 0",
                 i, m_valid, m_data, m_last, s_ready);
      end
      @(negedge clk);
    end
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (d0 !== 16'd10 || d1 !== 16'd10 || l1 !== 1'b1) begin
      errors++; $display("FAIL bp_release got %0d %0d last=%b want 10 10 1", d0, d1, l1);
    end
  endtask

  task automatic test_cfg_busy;
    logic [15:0] d0, d1, e0, e1; logic v0, l0, l1; int lat, w;
    fill(16'd1, 16'd1, 16'd0);
    send_frame(-1, w);
    for (int i = 0; i < 20; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = 16'd5;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (d0 !== 16'd10 || d1 !== 16'd10) begin
      errors++; $display("FAIL cfg_busy_same got %0d %0d want 10 10", d0, d1);
    end
    send_frame(-1, w);
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (d0 !== 16'd10 || d1 !== 16'd10) begin
      errors++; $display("FAIL cfg_busy_next got %0d %0d want 10 10", d0, d1);
    end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] d0, d1, e0, e1; logic v0, l0, l1; int lat, w;
    fill(16'd1, 16'd1, 16'd0);
    send_frame(-1, w);
    repeat (11) @(negedge clk);  // node 12 is being evaluated
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 16'h0
                  || m_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outs got b=%b v=%b r=%b d=%h l=%b want all 0",
               busy, m_valid, s_ready, m_data, m_last);
    end
    @(negedge clk);
    rst = 1'b0;
    send_frame(-1, w);
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (d0 !== 16'd2) begin errors++; $display("FAIL mid_n27 got %0d want 2", d0); end
    checks++; if (d1 !== 16'd2) begin errors++; $display("FAIL mid_n28 got %0d want 2", d1); end
  endtask

  task automatic test_wrap;
    logic [15:0] d0, d1, e0, e1; logic v0, l0, l1; int lat, w;
    fill(16'd0, 16'd0, 16'd0);
    frame[0] = 16'h7FFF; frame[1] = 16'd1; frame[2] = 16'h7FFF; frame[3] = 16'd1;
    send_frame(-1, w);
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (d0 !== 16'hFFFE) begin errors++; $display("FAIL wrap_n27 got %h want fffe", d0); end
    checks++; if (d1 !== 16'h0000) begin errors++; $display("FAIL wrap_n28 got %h want 0000", d1); end
    checks++; if (e0 !== 16'h00FE) begin errors++; $display("FAIL wrap_frac_n27 got %h want 00fe", e0); end
  endtask

  task automatic test_frac;
    logic [15:0] d0, d1, e0, e1; logic v0, l0, l1; int lat, w;
    fill(16'd0, 16'd0, 16'd0);
    frame[0] = 16'h0100; frame[1] = 16'h0100;
    send_frame(-1, w);
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (e0 !== 16'h0100) begin errors++; $display("FAIL frac_n27 got %h want 0100", e0); end
    checks++; if (e1 !== 16'h0000) begin errors++; $display("FAIL frac_n28 got %h want 0000", e1); end
    checks++; if (d0 !== 16'h0000) begin errors++; $display("FAIL frac0_trunc got %h want 0000", d0); end
    // -2.0 * 0.5 through n7 -> n12 -> n28 checks the arithmetic shift
    fill(16'd0, 16'd0, 16'd0);
    frame[12] = 16'hFE00; frame[13] = 16'h0080;
    send_frame(-1, w);
    collect(d0, d1, e0, e1, v0, l0, l1, lat);
    checks++; if (e1 !== 16'hFF00) begin errors++; $display("FAIL frac_neg_n28 got %h want ff00", e1); end
    checks++; if (e0 !== 16'h0000) begin errors++; $display("FAIL frac_neg_n27 got %h want 0000", e0); end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_cfg_busy();
    test_reset_midframe();
    test_wrap();
    test_frac();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
